// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot-stream loader that fills core memory and releases the core
//
// Accepts a byte stream (length hi, length lo, N big-endian 32-bit words,
// XOR checksum byte), writes each word to memory at BASE_ADDR + 4*k and
// asserts cpu_Run once the checksum matches.
//
// Ports:
//   clock      system clock, rising edge
//   rst        synchronous active-low reset
//   in_Valid   in_Byte carries a byte
//   in_Byte    stream byte
//   in_Ready   loader accepts a byte this cycle
//   mem_Write  one-cycle memory write strobe
//   mem_Adr    byte address of the write
//   mem_Wd     write data
//   cpu_Run    core may run
//   done       load finished with a good checksum
//   error      checksum mismatch

module program_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          COUNT_WIDTH = 16
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        in_Valid,
  input  logic [7:0]  in_Byte,
  output logic        in_Ready,
  output logic        mem_Write,
  output logic [31:0] mem_Adr,
  output logic [31:0] mem_Wd,
  output logic        cpu_Run,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t                 state;
  state_t                 state_next;

  logic [7:0]             len_hi;
  logic [COUNT_WIDTH-1:0] word_cnt;
  logic [COUNT_WIDTH-1:0] word_idx;
  logic [COUNT_WIDTH-1:0] idx_inc;
  logic [COUNT_WIDTH-1:0] len_n;
  logic [1:0]             byte_cnt;
  logic [23:0]            asm_word;
  logic [7:0]             chk;
  logic [31:0]            word_off;
  logic                   state_accepts;
  logic                   accept;

  // Ready is decoded straight from the state register (plus reset) so that
  // the accept term never loops back through the next-state logic.
  assign state_accepts = (state == LEN_HI) || (state == LEN_LO) ||
                         (state == DATA)   || (state == CHECK);
  assign in_Ready      = rst & state_accepts;
  assign accept        = in_Valid & in_Ready;

  assign len_n    = COUNT_WIDTH'({len_hi, in_Byte});
  assign idx_inc  = word_idx + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  assign word_off = 32'({word_idx, 2'b00});

  always_ff @(posedge clock) begin
    if (!rst) begin
      state <= LEN_HI;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    error      = 1'b0;
    cpu_Run    = 1'b0;
    case (state)
      LEN_HI: begin
        if (accept) state_next = LEN_LO;
      end
      LEN_LO: begin
        if (accept) state_next = (len_n == '0) ? CHECK : DATA;
      end
      DATA: begin
        if (accept && byte_cnt == 2'd3) state_next = WRITE;
      end
      WRITE: begin
        // Compare the post-increment index so N = 2^COUNT_WIDTH-1 never wraps.
        state_next = (idx_inc == word_cnt) ? CHECK : DATA;
      end
      CHECK: begin
        if (accept) state_next = (in_Byte == chk) ? DONE : ERROR;
      end
      DONE: begin
        done    = 1'b1;
        cpu_Run = 1'b1;
      end
      ERROR: begin
        error = 1'b1;
      end
      default: state_next = LEN_HI;
    endcase
  end

  // Datapath. The write strobe and bus are registered on the edge that
  // accepts the 4th byte, so they are valid exactly during WRITE.
  always_ff @(posedge clock) begin
    if (!rst) begin
      len_hi    <= 8'd0;
      word_cnt  <= '0;
      word_idx  <= '0;
      byte_cnt  <= 2'd0;
      asm_word  <= 24'd0;
      chk       <= 8'd0;
      mem_Write <= 1'b0;
      mem_Adr   <= BASE_ADDR;
      mem_Wd    <= 32'd0;
    end else begin
      mem_Write <= 1'b0;
      case (state)
        LEN_HI: begin
          if (accept) len_hi <= in_Byte;
        end
        LEN_LO: begin
          if (accept) word_cnt <= len_n;
        end
        DATA: begin
          if (accept) begin
            asm_word <= {asm_word[15:0], in_Byte};
            chk      <= chk ^ in_Byte;
            if (byte_cnt == 2'd3) begin
              byte_cnt  <= 2'd0;
              mem_Write <= 1'b1;
              mem_Adr   <= BASE_ADDR + word_off;
              mem_Wd    <= {asm_word, in_Byte};
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        WRITE: begin
          word_idx <= idx_inc;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader

module tb_program_loader;

  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam logic [31:0] BASE_B = 32'h0000_0400;

  logic        clock = 1'b0;
  logic        rst;
  logic        in_Valid;
  logic [7:0]  in_Byte;

  logic        a_in_Ready, a_mem_Write, a_cpu_Run, a_done, a_error;
  logic [31:0] a_mem_Adr, a_mem_Wd;
  logic        b_in_Ready, b_mem_Write, b_cpu_Run, b_done, b_error;
  logic [31:0] b_mem_Adr, b_mem_Wd;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    logic [31:0] off;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] load_words[$];
  logic [31:0] last_off = 32'd0;
  logic [31:0] last_wd  = 32'd0;
  bit          prev_wr  = 1'b0;
  bit          rst_edge_low = 1'b0;

  program_loader #(.BASE_ADDR(BASE_A), .COUNT_WIDTH(16)) dut_a (
    .clock(clock), .rst(rst), .in_Valid(in_Valid), .in_Byte(in_Byte),
    .in_Ready(a_in_Ready), .mem_Write(a_mem_Write), .mem_Adr(a_mem_Adr),
    .mem_Wd(a_mem_Wd), .cpu_Run(a_cpu_Run), .done(a_done), .error(a_error)
  );

  program_loader #(.BASE_ADDR(BASE_B), .COUNT_WIDTH(16)) dut_b (
    .clock(clock), .rst(rst), .in_Valid(in_Valid), .in_Byte(in_Byte),
    .in_Ready(b_in_Ready), .mem_Write(b_mem_Write), .mem_Adr(b_mem_Adr),
    .mem_Wd(b_mem_Wd), .cpu_Run(b_cpu_Run), .done(b_done), .error(b_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc          <= cyc + 1;
    rst_edge_low <= !rst;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory-side monitor: every strobe must match the next expected write,
  // and the address/data bus must hold the last write (or reset value).
  always @(negedge clock) begin : monitor
    wr_t e;
    if (rst_edge_low) begin
      last_off = 32'd0;
      last_wd  = 32'd0;
    end
    if (a_mem_Write) begin
      check_val("write_in_ready_low", {31'd0, a_in_Ready}, 32'd0);
      check_val("write_not_back_to_back", {31'd0, prev_wr}, 32'd0);
      if (exp_q.size() == 0) begin
        check_val("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("write_adr_a", a_mem_Adr, BASE_A + e.off);
        check_val("write_wd_a", a_mem_Wd, e.data);
        check_val("write_strobe_b", {31'd0, b_mem_Write}, 32'd1);
        check_val("write_adr_b", b_mem_Adr, BASE_B + e.off);
        check_val("write_wd_b", b_mem_Wd, e.data);
        last_off = e.off;
        last_wd  = e.data;
      end
    end else begin
      check_val("hold_adr", a_mem_Adr, BASE_A + last_off);
      check_val("hold_wd", a_mem_Wd, last_wd);
    end
    prev_wr = a_mem_Write;
  end

  task automatic do_reset();
    rst      = 1'b0;
    in_Valid = 1'($urandom_range(0, 1));
    in_Byte  = 8'($urandom);
    #1;
    check_val("rst_in_ready", {31'd0, a_in_Ready}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    check_val("rst_mem_write", {31'd0, a_mem_Write}, 32'd0);
    check_val("rst_mem_adr_a", a_mem_Adr, BASE_A);
    check_val("rst_mem_adr_b", b_mem_Adr, BASE_B);
    check_val("rst_mem_wd", a_mem_Wd, 32'd0);
    check_val("rst_outputs", {29'd0, a_cpu_Run, a_done, a_error}, 32'd0);
    rst      = 1'b1;
    in_Valid = 1'b0;
  endtask

  // mode 0: in_Valid held high; mode 1: toggles, held high while blocked;
  // mode 2: random gaps with junk bytes on the bus.
  // abort_after >= 0 resets the loader after that many accepted bytes.
  task automatic run_load(input int mode, input bit bad_chk, input int abort_after);
    logic [7:0]  bytes[$];
    logic [7:0]  chk;
    logic [15:0] n16;
    int          n;
    int          first_cyc;
    bit          tog;
    bit          acc;
    int          budget;

    n   = load_words.size();
    n16 = 16'(n);
    chk = 8'd0;
    bytes.push_back(n16[15:8]);
    bytes.push_back(n16[7:0]);
    foreach (load_words[k]) begin
      for (int s = 3; s >= 0; s--) begin
        bytes.push_back(8'(load_words[k] >> (8 * s)));
        chk ^= 8'(load_words[k] >> (8 * s));
      end
    end
    bytes.push_back(bad_chk ? (chk ^ 8'(1 << $urandom_range(0, 7))) : chk);

    tog       = 1'b1;
    first_cyc = 0;
    for (int i = 0; i < bytes.size(); i++) begin
      if (i == abort_after) begin
        do_reset();
        return;
      end
      acc    = 1'b0;
      budget = 64;
      while (!acc) begin
        if (budget == 0) begin
          check_val("accept_timeout", 32'd0, 32'd1);
          in_Valid = 1'b0;
          return;
        end
        budget--;
        case (mode)
          0:       in_Valid = 1'b1;
          1:       in_Valid = a_in_Ready ? tog : 1'b1;
          default: in_Valid = 1'($urandom_range(0, 1));
        endcase
        tog     = ~tog;
        in_Byte = in_Valid ? bytes[i] : 8'($urandom);
        #1;
        acc = in_Valid && a_in_Ready;
        if (acc) begin
          if (i == 0) first_cyc = cyc;
          if (i == bytes.size() - 1) begin
            check_val("done_before_chk", {31'd0, a_done}, 32'd0);
          end
          if (i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3) begin
            exp_q.push_back('{off: 32'(4 * ((i - 2) / 4)), data: load_words[(i - 2) / 4]});
          end
        end
        @(posedge clock);
        @(negedge clock);
      end
    end

    check_val("final_done", {31'd0, a_done}, {31'd0, !bad_chk});
    check_val("final_cpu_run", {31'd0, a_cpu_Run}, {31'd0, !bad_chk});
    check_val("final_error", {31'd0, a_error}, {31'd0, bad_chk});
    check_val("final_in_ready", {31'd0, a_in_Ready}, 32'd0);
    check_val("final_b", {29'd0, b_done, b_error, b_in_Ready}, {29'd0, !bad_chk, bad_chk, 1'b0});
    if (mode == 0) check_val("load_latency", 32'(cyc - first_cyc), 32'(2 + 5 * n + 1));

    in_Valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      in_Byte = 8'($urandom);
      @(posedge clock);
      @(negedge clock);
    end
    check_val("terminal_hold", {30'd0, a_done, a_error}, {30'd0, !bad_chk, bad_chk});
    check_val("pending_writes", 32'(exp_q.size()), 32'd0);
    in_Valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    in_Valid = 1'b0;
    in_Byte  = 8'd0;
    @(negedge clock);
    do_reset();

    load_words = '{32'h2008_0005, 32'h8C09_0004};
    run_load(0, 1'b0, -1);
    do_reset();

    load_words = '{};
    run_load(0, 1'b0, -1);
    do_reset();

    load_words = '{32'h2008_0005, 32'h8C09_0004};
    run_load(0, 1'b1, -1);
    do_reset();

    run_load(1, 1'b0, -1);
    do_reset();

    run_load(0, 1'b0, 2 + 2);
    load_words = '{32'hDEAD_BEEF};
    run_load(0, 1'b0, -1);
    do_reset();

    load_words = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
    run_load(0, 1'b0, -1);
    do_reset();

    for (int t = 0; t < 40; t++) begin
      int n;
      int abort_at;
      n = $urandom_range(0, 6);
      load_words = '{};
      for (int k = 0; k < n; k++) load_words.push_back($urandom);
      abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2 + 4 * n) : -1;
      run_load($urandom_range(0, 2), ($urandom_range(0, 3) == 0), abort_at);
      if (abort_at < 0) do_reset();
      check_val("queue_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
